// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH regs; ports clk, reset (async low), write/destreg/wrtData (sync write), srcreg1/2 -> rdata1/2 (comb read, optional bypass)
module register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] destreg,
  input  logic [DATA_WIDTH-1:0] wrtData,
  input  logic [ADDR_WIDTH-1:0] srcreg1,
  input  logic [ADDR_WIDTH-1:0] srcreg2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);
  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
  logic byp1, byp2;
  always_ff @(posedge clk or negedge reset)
    if (!reset) regs <= '{default: '0};
    else if (write) regs[destreg] <= wrtData;
  always_comb begin
    byp1 = BYPASS && write && destreg == srcreg1;
    byp2 = BYPASS && write && destreg == srcreg2;
    rdata1 = !reset ? '0 : byp1 ? wrtData : regs[srcreg1];
    rdata2 = !reset ? '0 : byp2 ? wrtData : regs[srcreg2];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file with and without bypass
module tb_register_file;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic write = 1'b0;
  logic [2:0] destreg = '0, srcreg1 = '0, srcreg2 = '0;
  logic [7:0] wrtData = '0;
  logic [7:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .write(write), .destreg(destreg), .wrtData(wrtData),
    .srcreg1(srcreg1), .srcreg2(srcreg2), .rdata1(rdata1), .rdata2(rdata2));

  register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .write(write), .destreg(destreg), .wrtData(wrtData),
    .srcreg1(srcreg1), .srcreg2(srcreg2), .rdata1(nb_rdata1), .rdata2(nb_rdata2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    write = 1'b0;
    repeat (2) tick();
    checks++;
    if ({rdata1, rdata2} !== 16'h0) begin
      failures++;
      $display("FAIL reset_held got=%h/%h exp=00/00", rdata1, rdata2);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      srcreg1 = 3'(i);
      srcreg2 = 3'(7 - i);
      #1;
      checks++;
      if ({rdata1, rdata2, nb_rdata1, nb_rdata2} !== 32'h0) begin
        failures++;
        $display("FAIL reset_read idx=%0d got=%h/%h/%h/%h exp=0", i, rdata1, rdata2, nb_rdata1, nb_rdata2);
      end
    end
  endtask

  task automatic test_write_read();
    write = 1'b1;
    destreg = 3'd1;
    wrtData = 8'd42;
    tick();
    destreg = 3'd2;
    wrtData = 8'd99;
    tick();
    write = 1'b0;
    srcreg1 = 3'd1;
    srcreg2 = 3'd2;
    #1;
    checks++;
    if ({rdata1, rdata2, nb_rdata1, nb_rdata2} !== {8'd42, 8'd99, 8'd42, 8'd99}) begin
      failures++;
      $display("FAIL write_read got=%0d/%0d/%0d/%0d exp=42/99/42/99", rdata1, rdata2, nb_rdata1, nb_rdata2);
    end
    wrtData = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      destreg = 3'(i + 1);
      tick();
      checks++;
      if ({rdata1, rdata2, nb_rdata1, nb_rdata2} !== {8'd42, 8'd99, 8'd42, 8'd99}) begin
        failures++;
        $display("FAIL write_disabled cyc=%0d got=%0d/%0d/%0d/%0d exp=42/99/42/99", i, rdata1, rdata2, nb_rdata1, nb_rdata2);
      end
    end
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({rdata1, rdata2, nb_rdata1, nb_rdata2} !== 32'h0) begin
      failures++;
      $display("FAIL reset_async got=%h/%h/%h/%h exp=0", rdata1, rdata2, nb_rdata1, nb_rdata2);
    end
    #9;
    reset = 1'b1;
    #1;
    checks++;
    if ({rdata1, rdata2, nb_rdata1, nb_rdata2} !== 32'h0) begin
      failures++;
      $display("FAIL reset_release got=%h/%h/%h/%h exp=0", rdata1, rdata2, nb_rdata1, nb_rdata2);
    end
    tick();
    checks++;
    if ({rdata1, rdata2} !== 16'h0) begin
      failures++;
      $display("FAIL reset_after_edge got=%h/%h exp=00/00", rdata1, rdata2);
    end
  endtask

  task automatic test_full();
    write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      destreg = 3'(i);
      wrtData = 8'(8'h10 + i);
      tick();
    end
    write = 1'b0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        srcreg1 = 3'(a);
        srcreg2 = 3'(b);
        #1;
        checks++;
        if (rdata1 !== 8'(8'h10 + a) || rdata2 !== 8'(8'h10 + b) || nb_rdata1 !== 8'(8'h10 + a) || nb_rdata2 !== 8'(8'h10 + b)) begin
          failures++;
          $display("FAIL full_pair %0d,%0d got=%h/%h/%h/%h exp=%h/%h", a, b, rdata1, rdata2, nb_rdata1, nb_rdata2, 8'(8'h10 + a), 8'(8'h10 + b));
        end
      end
    write = 1'b1;
    destreg = 3'd7;
    wrtData = 8'h5A;
    tick();
    wrtData = 8'hA5;
    tick();
    write = 1'b0;
    srcreg1 = 3'd7;
    srcreg2 = 3'd7;
    #1;
    checks++;
    if ({rdata1, rdata2, nb_rdata1, nb_rdata2} !== {4{8'hA5}}) begin
      failures++;
      $display("FAIL overwrite7 got=%h/%h/%h/%h exp=a5", rdata1, rdata2, nb_rdata1, nb_rdata2);
    end
  endtask

  task automatic test_bypass();
    srcreg1 = 3'd3;
    srcreg2 = 3'd4;
    write = 1'b1;
    destreg = 3'd3;
    wrtData = 8'd77;
    #1;
    checks++;
    if (rdata1 !== 8'd77 || rdata2 !== 8'h14) begin
      failures++;
      $display("FAIL bypass_pre got=%h/%h exp=4d/14", rdata1, rdata2);
    end
    checks++;
    if (nb_rdata1 !== 8'h13 || nb_rdata2 !== 8'h14) begin
      failures++;
      $display("FAIL nobypass_pre got=%h/%h exp=13/14", nb_rdata1, nb_rdata2);
    end
    tick();
    write = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 8'd77 || nb_rdata1 !== 8'd77) begin
      failures++;
      $display("FAIL bypass_post got=%h/%h exp=4d/4d", rdata1, nb_rdata1);
    end
  endtask

  task automatic test_write_during_reset();
    #2;
    reset = 1'b0;
    write = 1'b1;
    destreg = 3'd4;
    wrtData = 8'd55;
    srcreg1 = 3'd4;
    srcreg2 = 3'd4;
    #1;
    checks++;
    if ({rdata1, rdata2} !== 16'h0) begin
      failures++;
      $display("FAIL bypass_in_reset got=%h/%h exp=00/00", rdata1, rdata2);
    end
    repeat (2) tick();
    write = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({rdata1, rdata2, nb_rdata1, nb_rdata2} !== 32'h0) begin
      failures++;
      $display("FAIL write_in_reset got=%h/%h/%h/%h exp=0", rdata1, rdata2, nb_rdata1, nb_rdata2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reset_mid();
    test_full();
    test_bypass();
    test_write_during_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
